// File: rtl/uart_dbg_master.sv
// UART debug bridge: receives W/R commands over an 8N1 serial line, runs one 32-bit bus access and answers.
// Optional CPU-hold commands ('H'/'G') are compiled in with UART_DBG_MASTER_HOLD_EN.
module uart_dbg_master #(
  parameter int CLK_DIV     = 104,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_END   = TW'(BUS_TIMEOUT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_valid_q;

  logic [9:0]    tx_sh_q;
  logic          tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic          tx_start_s;
  logic [7:0]    tx_byte_s;

  logic [2:0]    state_q, state_d;
  logic          op_w_q, op_w_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          valid_q, valid_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    left_q, left_d;
`ifdef UART_DBG_MASTER_HOLD_EN
  logic          hold_q, hold_d;
`endif

  // Receiver: two-flop synchroniser, start confirmed at half-bit, bits sampled at centres.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_st_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q <= '0;
            rx_bit_q <= 3'd0;
            rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1'b1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1'b1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_valid_q <= rx_s2_q;
            rx_st_q    <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1'b1);
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: the line is bit 0 of a frame shifter that refills with idle ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh_q   <= 10'h3FF;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= 4'd0;
    end else if (!tx_busy_q) begin
      if (tx_start_s) begin
        tx_sh_q   <= {1'b1, tx_byte_s, 1'b0};
        tx_busy_q <= 1'b1;
        tx_cnt_q  <= '0;
        tx_bit_q  <= 4'd0;
      end
    end else if (tx_cnt_q == BIT_END) begin
      tx_cnt_q <= '0;
      tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      else                  tx_bit_q  <= tx_bit_q + 4'd1;
    end else begin
      tx_cnt_q <= tx_cnt_q + CW'(1'b1);
    end
  end

  assign tx_byte_s = resp_q[7:0];

  // Command sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    op_w_d     = op_w_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    wstrb_d    = wstrb_q;
    tcnt_d     = tcnt_q;
    resp_d     = resp_q;
    left_d     = left_q;
    tx_start_s = 1'b0;
`ifdef UART_DBG_MASTER_HOLD_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (rx_valid_q) begin
          if (rx_sh_q == 8'h57) begin
            op_w_d  = 1'b1;
            state_d = S_ADDR;
          end else if (rx_sh_q == 8'h52) begin
            op_w_d  = 1'b0;
            state_d = S_ADDR;
          end
`ifdef UART_DBG_MASTER_HOLD_EN
          else if (rx_sh_q == 8'h48 || rx_sh_q == 8'h47) begin
            hold_d  = (rx_sh_q == 8'h48);
            resp_d  = 32'h0000_004B;
            left_d  = 3'd1;
            state_d = S_RESP;
          end
`endif
          else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_valid_q) begin
          addr_d = {rx_sh_q, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (op_w_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_BUS;
              valid_d = 1'b1;
              wstrb_d = 4'h0;
              tcnt_d  = '0;
            end
          end else begin
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        if (rx_valid_q) begin
          wdata_d = {rx_sh_q, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            valid_d = 1'b1;
            wstrb_d = 4'hF;
            tcnt_d  = '0;
          end else begin
            state_d = S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_BUS: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          wstrb_d = 4'h0;
          resp_d  = op_w_q ? 32'h0000_004B : mem_rdata;
          left_d  = op_w_q ? 3'd1 : 3'd4;
          state_d = S_RESP;
        end else if (tcnt_q == TO_END) begin
          valid_d = 1'b0;
          wstrb_d = 4'h0;
          resp_d  = 32'h0000_0045;
          left_d  = 3'd1;
          state_d = S_RESP;
        end else begin
          tcnt_d  = tcnt_q + TW'(1'b1);
        end
      end
      S_RESP: begin
        if (left_q == 3'd0) begin
          state_d = S_IDLE;
        end else if (!tx_busy_q) begin
          tx_start_s = 1'b1;
          resp_d     = {8'h00, resp_q[31:8]};
          left_d     = left_q - 3'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command sequencer state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_w_q  <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      wstrb_q <= 4'h0;
      tcnt_q  <= '0;
      resp_q  <= 32'h0000_0000;
      left_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      op_w_q  <= op_w_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      tcnt_q  <= tcnt_d;
      resp_q  <= resp_d;
      left_q  <= left_d;
    end
  end

`ifdef UART_DBG_MASTER_HOLD_EN
  // CPU hold flag.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= hold_d;
  end
  assign cpu_hold = hold_q;
`else
  assign cpu_hold = 1'b0;
`endif

  assign ser_tx    = tx_sh_q[0];
  assign mem_valid = valid_q;
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_uart_dbg_master.sv
// Scoreboard bench for uart_dbg_master: expected bus accesses and TX bytes are queued by the
// stimulus and consumed by independent bus and serial monitors.
module tb_uart_dbg_master;
  localparam int CLK_DIV     = 8;
  localparam int BUS_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_hold;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [7:0]  exp_tx_q[$];
  int          checks = 0;
  int          failures = 0;
  int          bus_mode = 0;   // 0: ready same cycle, 1: one cycle later, 2: never
  int          cur_len = 0;
  int          last_len = 0;

  uart_dbg_master #(.CLK_DIV(CLK_DIV), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responder model
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        wait_cnt++;
        mem_ready = (bus_mode == 0) || (bus_mode == 1 && wait_cnt >= 2);
      end else begin
        wait_cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Length of the most recent mem_valid pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst) cur_len = 0;
      else if (mem_valid) cur_len++;
      else if (cur_len != 0) begin
        last_len = cur_len;
        cur_len = 0;
      end
    end
  end

  // Bus monitor
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_valid && mem_ready) begin
        if (exp_bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected actual_addr=%h required=none", mem_addr);
        end else begin
          e = exp_bus_q.pop_front();
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          if (e.wstrb == 4'hF) chk("bus_wdata", mem_wdata, e.wdata);
        end
        @(negedge clk);
        chk("valid_drop", 32'(mem_valid), 32'd0);
      end
    end
  end

  // Serial TX monitor
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && ser_tx === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        chk("tx_stop", 32'(ser_tx), 32'd1);
        if (exp_tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%h required=none", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_t e;
    e.addr = a;
    e.wdata = d;
    e.wstrb = s;
    exp_bus_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx_q.size() != 0 || exp_bus_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_tx_q.size() != 0 || exp_bus_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", exp_tx_q.size() + exp_bus_q.size());
    end
    repeat (3 * CLK_DIV) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_tx", 32'(ser_tx), 32'd1);
    rst = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_valid", 32'(mem_valid), 32'd0);
    chk("reset_tx", 32'(ser_tx), 32'd1);
    chk("reset_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_hold", 32'(cpu_hold), 32'd0);
    rst = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);

    // write, ready one cycle after valid
    bus_mode = 1;
    push_bus(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0010);
    send_word(32'hDEAD_BEEF);
    drain();
    chk("len_write", 32'(last_len), 32'd2);

    // read, ready in the same cycle
    bus_mode = 0;
    mem_rdata = 32'h1234_5678;
    push_bus(32'h0200_0008, 32'h0, 4'h0);
    exp_tx_q.push_back(8'h78); exp_tx_q.push_back(8'h56);
    exp_tx_q.push_back(8'h34); exp_tx_q.push_back(8'h12);
    send_byte(8'h52, 1'b1);
    send_word(32'h0200_0008);
    drain();
    chk("len_read", 32'(last_len), 32'd1);

    // unaligned address bits are forced to zero on the bus
    mem_rdata = 32'hA5A5_0F0F;
    push_bus(32'h8000_0008, 32'h0, 4'h0);
    exp_tx_q.push_back(8'h0F); exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'hA5); exp_tx_q.push_back(8'hA5);
    send_byte(8'h52, 1'b1);
    send_word(32'h8000_000B);
    drain();

    // bus timeout
    bus_mode = 2;
    exp_tx_q.push_back(8'h45);
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0020);
    drain();
    chk("len_timeout", 32'(last_len), BUS_TIMEOUT);
    chk("timeout_valid", 32'(mem_valid), 32'd0);
    bus_mode = 1;
    push_bus(32'h0000_0024, 32'h0403_0201, 4'hF);
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0024);
    send_word(32'h0403_0201);
    drain();

    // junk byte and a bad-stop 'W' are ignored
    bus_mode = 0;
    mem_rdata = 32'hCAFE_F00D;
    send_byte(8'h00, 1'b1);
    send_byte(8'h57, 1'b0);
    push_bus(32'h0000_0040, 32'h0, 4'h0);
    exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'hFE); exp_tx_q.push_back(8'hCA);
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0040);
    drain();

`ifdef UART_DBG_MASTER_HOLD_EN
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h48, 1'b1);
    drain();
    chk("hold_set", 32'(cpu_hold), 32'd1);
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h47, 1'b1);
    drain();
    chk("hold_clr", 32'(cpu_hold), 32'd0);
`else
    send_byte(8'h48, 1'b1);
    repeat (30 * CLK_DIV) @(negedge clk);
    chk("hold_off", 32'(cpu_hold), 32'd0);
`endif

    // reset during write data bytes
    bus_mode = 1;
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0010);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    pulse_reset();
    push_bus(32'h0000_0030, 32'h4433_2211, 4'hF);
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0030);
    send_word(32'h4433_2211);
    drain();

    // reset during the bus wait
    bus_mode = 2;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0050);
    begin
      int n = 0;
      while (!mem_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("bus_wait_seen", 32'(mem_valid), 32'd1);
    end
    repeat (2) @(negedge clk);
    pulse_reset();
    repeat (30 * CLK_DIV) @(negedge clk);
    chk("no_resp_valid", 32'(mem_valid), 32'd0);
    bus_mode = 1;
    push_bus(32'h0000_0060, 32'h0BAD_F00D, 4'hF);
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0060);
    send_word(32'h0BAD_F00D);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
